regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised integer register file with per-register busy scoreboard for the pipelined TinyRisc-V core. It provides NRD combinational read ports, one synchronous write-back port, and one issue port. The issue port marks a destination register busy until its result is written back. It sits between decode (issue/read) and write-back, and supplies operands plus hazard status to the issue logic.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥2)
- NRD, 2, number of read ports (1–4)
- AW, $clog2(NREGS), register index width (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rs_num  in  NRD*AW  read indices; port i at bits [i*AW +: AW]
- rs_data  out  NRD*XLEN  read data; port i at [i*XLEN +: XLEN]
- rs_busy  out  NRD  port i source has an outstanding producer
- w_enable  in  1  write-back strobe
- rd_num  in  AW  write-back index
- rd_data  in  XLEN  write-back data
- issue_valid  in  1  mark issue_rd busy
- issue_rd  in  AW  destination being issued
- flush  in  1  clear all busy bits (pipeline squash)
- busy_count  out  $clog2(NREGS)+1  number of busy registers

## Operation
- Storage: NREGS × XLEN registers plus NREGS busy bits.
- Register 0 reads as 0 and is never busy. Writes and issues to index 0 are ignored.
- Read: rs_data[i] = reg[rs_num[i]]; rs_busy[i] = busy[rs_num[i]]. Both are combinational.
- Write-back: when w_enable && rd_num≠0, reg[rd_num] ← rd_data and busy[rd_num] ← 0 at the edge. Writing back to a non-busy register is legal and updates the data.
- Issue: when issue_valid && issue_rd≠0, busy[issue_rd] ← 1 at the edge. Issuing an already-busy register is legal; it stays busy.
- Same-cycle issue and write-back to the same index: data is written and busy ends at 1 (issue wins, because a newer producer exists).
- flush: all busy bits ← 0 at the edge. Register data is unaffected. A write-back in the same cycle still writes data. An issue in the same cycle is discarded (flush wins).
- busy_count: registered population count of the busy bits, updated in the same edge as the busy bits. It never exceeds NREGS-1.
- Reset: all registers ← 0, all busy ← 0, busy_count ← 0. Reset overrides w_enable, issue_valid and flush in the same cycle.

## Timing
- Read latency is 0 cycles from rs_num.
- Write-back data is visible on rs_data the cycle after the w_enable edge. With bypass enabled it is visible in the same cycle.
- Issue sets rs_busy from the cycle after the edge.
- busy_count lags the busy bits by 0 cycles: both are registered at the same edge.
- Output values under reset: rs_data = 0 and rs_busy = 0 from the cycle after the rst edge.
- Reset asserted mid-operation (with busy registers outstanding) returns all state to its reset values after one edge.

## Configuration
- REGFILE_BYPASS_EN defined: when w_enable && rd_num==rs_num[i] && rd_num≠0, then rs_data[i] = rd_data and rs_busy[i] = 0 in the same cycle. If issue_valid targets the same index in that cycle, rs_busy[i] is still 0, because the busy bit only rises at the edge.
- Not defined: reads return stored values only, and the written value appears one cycle later.

## Structure
- Shared package regfile_pkg: XLEN and NREGS defaults, the AW derivation function, and the zero-register index constant REG_ZERO.
- Sub-module regfile_rdport: one read mux plus optional bypass, instantiated NRD times in a generate loop.
- The busy scoreboard and popcount stay in the top module.

## Test plan
- Reset with rst=1 for 1 edge, then read all indices on ports 0/1 → every rs_data = 0, rs_busy = 0, busy_count = 0.
- Write x3 = 0x0000000A with w_enable=1 and rd_num=3; set rs_num = {3,1} → after the edge rs_data port0 = 0x0A and port1 = 0. With REGFILE_BYPASS_EN, port0 = 0x0A already in the write cycle.
- Issue x5, then write back 0xDEADBEEF to x5 two cycles later → rs_busy for x5 is 1 for 2 cycles, then 0; busy_count goes 0→1→1→0; data is 0xDEADBEEF.
- Write x0 = 0xFFFFFFFF and issue x0 → x0 reads 0, x0 is never busy, busy_count = 0.
- Same cycle: issue x7 and write back x7 = 0x55 → x7 = 0x55 and rs_busy = 1 afterwards. Next cycle: issue x8 and x9, then flush plus issue x10 → all busy = 0, busy_count = 0, x7 data still 0x55.
- Set busy on x1..x4, then assert rst alongside issue x6 and write x2 = 0x99 → after the edge all busy = 0, x2 = 0, busy_count = 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the TinyRisc-V integer register file slice:
// default data width and register count, the index-width derivation
// function, and the hard-wired zero register index.
// No ports (package).
// Optional feature macro used elsewhere in this slice: REGFILE_BYPASS_EN
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int NRD_DEFAULT   = 2;

    // Register x0 is architecturally zero: never stored, never busy.
    localparam int REG_ZERO = 0;

    // Width of a register index for a file of nregs entries.
    function automatic int calcAw(input int nregs);
        return $clog2(nregs);
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// ---------------------------------------------------------------------------
// regfile_sb_if
// Bundles the decode/issue/write-back side of the register file.
//   rs_num      read indices, port i at [i*AW +: AW]
//   rs_data     read data, port i at [i*XLEN +: XLEN]
//   rs_busy     per-port "source has an outstanding producer"
//   w_enable    write-back strobe, with rd_num / rd_data
//   issue_valid issue strobe, with issue_rd (destination marked busy)
//   flush       clears every busy bit
//   busy_count  registered number of busy registers
// Modports: master (decode/write-back side), slave (register file).
// Optional feature macro (consumed by the register file): REGFILE_BYPASS_EN
// ---------------------------------------------------------------------------
interface regfile_sb_if #(
    parameter int XLEN  = regfile_pkg::XLEN_DEFAULT,
    parameter int NREGS = regfile_pkg::NREGS_DEFAULT,
    parameter int NRD   = regfile_pkg::NRD_DEFAULT
) ();
    import regfile_pkg::*;

    localparam int AW = calcAw(NREGS);

    logic [NRD*AW-1:0]   rs_num;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic                w_enable;
    logic [AW-1:0]       rd_num;
    logic [XLEN-1:0]     rd_data;
    logic                issue_valid;
    logic [AW-1:0]       issue_rd;
    logic                flush;
    logic [AW:0]         busy_count;

    modport master (
        output rs_num, w_enable, rd_num, rd_data, issue_valid, issue_rd, flush,
        input  rs_data, rs_busy, busy_count
    );

    modport slave (
        input  rs_num, w_enable, rd_num, rd_data, issue_valid, issue_rd, flush,
        output rs_data, rs_busy, busy_count
    );

endinterface

// File: rtl/regfile_rdport.sv
// ---------------------------------------------------------------------------
// regfile_rdport
// One combinational read port: selects a register and its busy bit.
//   i_rs_num     register index to read
//   i_regs_flat  all registers, register k at [k*XLEN +: XLEN]
//   i_busy       all busy bits
//   i_w_enable, i_rd_num, i_rd_data   write-back bus (bypass builds only)
//   o_rs_data    selected data
//   o_rs_busy    selected busy bit
// Macro REGFILE_BYPASS_EN: forward the in-flight write-back to this port.
// ---------------------------------------------------------------------------
module regfile_rdport #(
    parameter int XLEN  = regfile_pkg::XLEN_DEFAULT,
    parameter int NREGS = regfile_pkg::NREGS_DEFAULT,
    parameter int AW    = regfile_pkg::calcAw(NREGS)
) (
    input  logic [AW-1:0]         i_rs_num,
    input  logic [NREGS*XLEN-1:0] i_regs_flat,
    input  logic [NREGS-1:0]      i_busy,
`ifdef REGFILE_BYPASS_EN
    input  logic                  i_w_enable,
    input  logic [AW-1:0]         i_rd_num,
    input  logic [XLEN-1:0]       i_rd_data,
`endif
    output logic [XLEN-1:0]       o_rs_data,
    output logic                  o_rs_busy
);
    import regfile_pkg::*;

    always_comb begin
        o_rs_data = i_regs_flat[int'(i_rs_num)*XLEN +: XLEN];
        o_rs_busy = i_busy[i_rs_num];
        // x0 is forced to zero here so the port never depends on storage.
        if (i_rs_num == AW'(REG_ZERO)) begin
            o_rs_data = '0;
            o_rs_busy = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        // A write-back in this cycle satisfies the producer, so the operand
        // is ready now even if a same-cycle issue will re-arm busy at the edge.
        if (i_w_enable && (i_rd_num == i_rs_num) && (i_rd_num != AW'(REG_ZERO))) begin
            o_rs_data = i_rd_data;
            o_rs_busy = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
// Integer register file with a per-register busy scoreboard.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  regfile_sb_if.slave: NRD read ports, write-back port, issue port,
//        flush, and registered busy_count
// Macro REGFILE_BYPASS_EN: read ports see the same-cycle write-back.
// ---------------------------------------------------------------------------
module regfile_sb #(
    parameter int XLEN  = regfile_pkg::XLEN_DEFAULT,
    parameter int NREGS = regfile_pkg::NREGS_DEFAULT,
    parameter int NRD   = regfile_pkg::NRD_DEFAULT
) (
    input logic        clk,
    input logic        rst,
    regfile_sb_if.slave bus
);
    import regfile_pkg::*;

    localparam int AW = calcAw(NREGS);
    localparam int CW = AW + 1;

    logic [XLEN-1:0]       r_regs [NREGS];
    logic [NREGS-1:0]      r_busy;
    logic [CW-1:0]         r_busy_count;

    logic                  w_wb_hit;
    logic                  w_issue_hit;
    logic [NREGS-1:0]      w_busy_next;
    logic [CW-1:0]         w_busy_pop;
    logic [NREGS*XLEN-1:0] w_regs_flat;
    logic [NRD*XLEN-1:0]   w_rs_data;
    logic [NRD-1:0]        w_rs_busy;

    assign w_wb_hit    = bus.w_enable    && (bus.rd_num   != AW'(REG_ZERO));
    assign w_issue_hit = bus.issue_valid && (bus.issue_rd != AW'(REG_ZERO));

    // Next busy vector. Issue is applied after write-back so a newer producer
    // to the same register keeps it busy; flush discards both.
    always_comb begin
        w_busy_next = r_busy;
        if (bus.flush) begin
            w_busy_next = '0;
        end else begin
            if (w_wb_hit) begin
                w_busy_next[bus.rd_num] = 1'b0;
            end
            if (w_issue_hit) begin
                w_busy_next[bus.issue_rd] = 1'b1;
            end
        end
        w_busy_next[REG_ZERO] = 1'b0;
    end

    // Population count of the next busy vector, so the registered count
    // lands on the same edge as the busy bits themselves.
    always_comb begin
        w_busy_pop = '0;
        for (int k = 0; k < NREGS; k++) begin
            w_busy_pop = w_busy_pop + CW'(w_busy_next[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREGS; k++) begin
                r_regs[k] <= '0;
            end
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            if (w_wb_hit) begin
                r_regs[bus.rd_num] <= bus.rd_data;
            end
            r_busy       <= w_busy_next;
            r_busy_count <= w_busy_pop;
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign w_regs_flat[g*XLEN +: XLEN] = r_regs[g];
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rdport
        regfile_rdport #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .AW    (AW)
        ) u_rdport (
            .i_rs_num    (bus.rs_num[g*AW +: AW]),
            .i_regs_flat (w_regs_flat),
            .i_busy      (r_busy),
`ifdef REGFILE_BYPASS_EN
            .i_w_enable  (bus.w_enable),
            .i_rd_num    (bus.rd_num),
            .i_rd_data   (bus.rd_data),
`endif
            .o_rs_data   (w_rs_data[g*XLEN +: XLEN]),
            .o_rs_busy   (w_rs_busy[g])
        );
    end

    assign bus.rs_data    = w_rs_data;
    assign bus.rs_busy    = w_rs_busy;
    assign bus.busy_count = r_busy_count;

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb
// Self-checking bench for regfile_sb (XLEN=32, NREGS=32, NRD=2).
// Expected read results are queued when stimulus is driven and compared
// when the outputs are sampled. Build with REGFILE_BYPASS_EN to check the
// bypass variant.
// ---------------------------------------------------------------------------
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        string       name;
        int          port;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb [$];

    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] portData(input int p);
        return bus.rs_data[p*XLEN +: XLEN];
    endfunction

    function automatic logic portBusy(input int p);
        return bus.rs_busy[p];
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setRead(input int p0, input int p1);
        bus.rs_num = {AW'(p1), AW'(p0)};
    endtask

    task automatic expectPort(input string name, input int port, input logic [31:0] data, input logic busy);
        sb.push_back('{name, port, data, busy});
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < NREGS; i += 2) begin
            setRead(i, i + 1);
            expectPort("reset_read", 0, 32'h0, 1'b0);
            expectPort("reset_read", 1, 32'h0, 1'b0);
            #1;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (portData(e.port) !== e.data || portBusy(e.port) !== e.busy) begin
                    errors++;
                    $display("[TB] FAIL %s x%0d: port%0d data=%h busy=%b, required data=%h busy=%b",
                             e.name, i + e.port, e.port, portData(e.port), portBusy(e.port), e.data, e.busy);
                end
            end
        end
        checks++;
        if (bus.busy_count !== 6'd0) begin
            errors++;
            $display("[TB] FAIL reset_count: got %0d, required 0", bus.busy_count);
        end
    endtask

    task automatic test_write();
        exp_t e;
        setRead(3, 1);
        bus.w_enable = 1'b1;
        bus.rd_num   = 5'd3;
        bus.rd_data  = 32'h0000000A;
        expectPort("write_same_cycle", 0, BYPASS ? 32'h0000000A : 32'h0, 1'b0);
        expectPort("write_same_cycle", 1, 32'h0, 1'b0);
        #1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (portData(e.port) !== e.data || portBusy(e.port) !== e.busy) begin
                errors++;
                $display("[TB] FAIL %s: port%0d data=%h busy=%b, required data=%h busy=%b",
                         e.name, e.port, portData(e.port), portBusy(e.port), e.data, e.busy);
            end
        end
        cycle();
        bus.w_enable = 1'b0;
        expectPort("write_after_edge", 0, 32'h0000000A, 1'b0);
        expectPort("write_after_edge", 1, 32'h0, 1'b0);
        #1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (portData(e.port) !== e.data || portBusy(e.port) !== e.busy) begin
                errors++;
                $display("[TB] FAIL %s: port%0d data=%h busy=%b, required data=%h busy=%b",
                         e.name, e.port, portData(e.port), portBusy(e.port), e.data, e.busy);
            end
        end
    endtask

    task automatic test_issue_writeback();
        exp_t e;
        logic [5:0] cntExp [4];
        cntExp = '{6'd0, 6'd1, 6'd1, 6'd0};
        setRead(5, 0);
        for (int step = 0; step < 4; step++) begin
            bus.issue_valid = (step == 0);
            bus.issue_rd    = 5'd5;
            bus.w_enable    = (step == 2);
            bus.rd_num      = 5'd5;
            bus.rd_data     = 32'hDEADBEEF;
            case (step)
                0: expectPort("issue_x5", 0, 32'h0, 1'b0);
                1: expectPort("busy_x5_c1", 0, 32'h0, 1'b1);
                2: expectPort("busy_x5_c2", 0, BYPASS ? 32'hDEADBEEF : 32'h0, !BYPASS);
                default: expectPort("wb_x5_done", 0, 32'hDEADBEEF, 1'b0);
            endcase
            #1;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (portData(e.port) !== e.data || portBusy(e.port) !== e.busy) begin
                    errors++;
                    $display("[TB] FAIL %s: port%0d data=%h busy=%b, required data=%h busy=%b",
                             e.name, e.port, portData(e.port), portBusy(e.port), e.data, e.busy);
                end
            end
            checks++;
            if (bus.busy_count !== cntExp[step]) begin
                errors++;
                $display("[TB] FAIL issue_wb_count step%0d: got %0d, required %0d", step, bus.busy_count, cntExp[step]);
            end
            if (step < 3) cycle();
        end
        bus.issue_valid = 1'b0;
        bus.w_enable    = 1'b0;
    endtask

    task automatic test_zero_reg();
        exp_t e;
        setRead(0, 0);
        bus.w_enable    = 1'b1;
        bus.rd_num      = 5'd0;
        bus.rd_data     = 32'hFFFFFFFF;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd0;
        expectPort("x0_same_cycle", 0, 32'h0, 1'b0);
        cycle();
        bus.w_enable    = 1'b0;
        bus.issue_valid = 1'b0;
        expectPort("x0_after", 0, 32'h0, 1'b0);
        expectPort("x0_after", 1, 32'h0, 1'b0);
        #1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (portData(e.port) !== e.data || portBusy(e.port) !== e.busy) begin
                errors++;
                $display("[TB] FAIL %s: port%0d data=%h busy=%b, required data=%h busy=%b",
                         e.name, e.port, portData(e.port), portBusy(e.port), e.data, e.busy);
            end
        end
        checks++;
        if (bus.busy_count !== 6'd0) begin
            errors++;
            $display("[TB] FAIL x0_count: got %0d, required 0", bus.busy_count);
        end
    endtask

    task automatic test_same_cycle_and_flush();
        exp_t e;
        logic [5:0] cntExp [4];
        cntExp = '{6'd1, 6'd2, 6'd3, 6'd0};
        setRead(7, 0);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        bus.w_enable    = 1'b1;
        bus.rd_num      = 5'd7;
        bus.rd_data     = 32'h00000055;
        cycle();
        bus.w_enable = 1'b0;
        expectPort("x7_issue_wins", 0, 32'h00000055, 1'b1);
        // issue x8, issue x9, then flush with issue x10
        for (int step = 0; step < 4; step++) begin
            bus.issue_valid = (step < 3);
            bus.issue_rd    = AW'(8 + step);
            bus.flush       = (step == 2);
            #1;
            checks++;
            if (bus.busy_count !== cntExp[step]) begin
                errors++;
                $display("[TB] FAIL flush_seq_count step%0d: got %0d, required %0d", step, bus.busy_count, cntExp[step]);
            end
            if (step < 3) cycle();
        end
        bus.flush = 1'b0;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            setRead(7, 0);
            #1;
            checks++;
            if (portData(e.port) !== 32'h00000055 || portBusy(e.port) !== 1'b0) begin
                errors++;
                $display("[TB] FAIL x7_after_flush: data=%h busy=%b, required data=00000055 busy=0",
                         portData(e.port), portBusy(e.port));
            end
        end
        setRead(8, 9);
        expectPort("flushed_x8", 0, 32'h0, 1'b0);
        expectPort("flushed_x9", 1, 32'h0, 1'b0);
        #1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (portData(e.port) !== e.data || portBusy(e.port) !== e.busy) begin
                errors++;
                $display("[TB] FAIL %s: port%0d data=%h busy=%b, required data=%h busy=%b",
                         e.name, e.port, portData(e.port), portBusy(e.port), e.data, e.busy);
            end
        end
        setRead(10, 7);
        #1;
        checks++;
        if (portBusy(0) !== 1'b0 || portBusy(1) !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flushed_x10_x7_busy: got %b%b, required 00", portBusy(1), portBusy(0));
        end
    endtask

    task automatic test_full_count();
        exp_t e;
        bus.issue_valid = 1'b1;
        for (int i = 0; i < NREGS; i++) begin
            bus.issue_rd = AW'(i);
            cycle();
        end
        bus.issue_valid = 1'b0;
        setRead(0, 31);
        expectPort("full_x0", 0, 32'h0, 1'b0);
        expectPort("full_x31", 1, 32'h0, 1'b1);
        #1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (portData(e.port) !== e.data || portBusy(e.port) !== e.busy) begin
                errors++;
                $display("[TB] FAIL %s: port%0d data=%h busy=%b, required data=%h busy=%b",
                         e.name, e.port, portData(e.port), portBusy(e.port), e.data, e.busy);
            end
        end
        checks++;
        if (bus.busy_count !== 6'd31) begin
            errors++;
            $display("[TB] FAIL full_count: got %0d, required 31", bus.busy_count);
        end
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        #1;
        checks++;
        if (bus.busy_count !== 6'd0) begin
            errors++;
            $display("[TB] FAIL full_flush_count: got %0d, required 0", bus.busy_count);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] vals [4];
        for (int k = 0; k < 4; k++) vals[k] = $urandom();
        bus.w_enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.rd_num  = AW'(11 + k);
            bus.rd_data = vals[k];
            setRead(10 + k, 0);
            expectPort("b2b_prev", 0, (k == 0) ? 32'h0 : vals[k-1], 1'b0);
            #1;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (portData(e.port) !== e.data || portBusy(e.port) !== e.busy) begin
                    errors++;
                    $display("[TB] FAIL %s k=%0d: data=%h busy=%b, required data=%h busy=%b",
                             e.name, k, portData(e.port), portBusy(e.port), e.data, e.busy);
                end
            end
            cycle();
        end
        bus.w_enable = 1'b0;
        for (int k = 0; k < 4; k += 2) begin
            setRead(11 + k, 12 + k);
            expectPort("b2b_final", 0, vals[k], 1'b0);
            expectPort("b2b_final", 1, vals[k+1], 1'b0);
            #1;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (portData(e.port) !== e.data || portBusy(e.port) !== e.busy) begin
                    errors++;
                    $display("[TB] FAIL %s x%0d: data=%h busy=%b, required data=%h busy=%b",
                             e.name, 11 + k + e.port, portData(e.port), portBusy(e.port), e.data, e.busy);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        exp_t e;
        bus.issue_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.issue_rd = AW'(i);
            cycle();
        end
        bus.issue_valid = 1'b0;
        #1;
        checks++;
        if (bus.busy_count !== 6'd4) begin
            errors++;
            $display("[TB] FAIL midop_count_before: got %0d, required 4", bus.busy_count);
        end
        rst             = 1'b1;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd6;
        bus.w_enable    = 1'b1;
        bus.rd_num      = 5'd2;
        bus.rd_data     = 32'h00000099;
        cycle();
        rst             = 1'b0;
        bus.issue_valid = 1'b0;
        bus.w_enable    = 1'b0;
        for (int i = 1; i <= 13; i += 2) begin
            setRead(i, i + 1);
            expectPort("midop_reset", 0, 32'h0, 1'b0);
            expectPort("midop_reset", 1, 32'h0, 1'b0);
            #1;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (portData(e.port) !== e.data || portBusy(e.port) !== e.busy) begin
                    errors++;
                    $display("[TB] FAIL %s x%0d: data=%h busy=%b, required data=%h busy=%b",
                             e.name, i + e.port, portData(e.port), portBusy(e.port), e.data, e.busy);
                end
            end
        end
        checks++;
        if (bus.busy_count !== 6'd0) begin
            errors++;
            $display("[TB] FAIL midop_count_after: got %0d, required 0", bus.busy_count);
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        bus.rs_num      = '0;
        bus.w_enable    = 1'b0;
        bus.rd_num      = '0;
        bus.rd_data     = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.flush       = 1'b0;
        test_reset();
        test_write();
        test_issue_writeback();
        test_zero_reg();
        test_same_cycle_and_flush();
        test_full_count();
        test_back_to_back();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
